// File: rtl/key_press_pkg.sv
// ---------------------------------------------------------------------------
// key_press_pkg
// Shared types and defaults for the key press conditioner.
//   key_state_t           : per-channel debounce state
//   DEFAULT_STABLE_TICKS  : consecutive equal samples needed to accept a level
//   DEFAULT_REPEAT_TICKS  : ticks between auto-repeat pulses while held
//   cnt_width()           : width of a counter that must hold values 0..n-1
// ---------------------------------------------------------------------------
package key_press_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESSING  = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } key_state_t;

  localparam int DEFAULT_STABLE_TICKS = 3;
  localparam int DEFAULT_REPEAT_TICKS = 8;

  // Never returns 0, so a counter for n == 1 still gets one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// ---------------------------------------------------------------------------
// key_debounce_channel
// One key: two-flop synchronizer, debounce FSM with stability counter and,
// when KEY_PRESS_CONDITIONER_AUTOREPEAT_EN is defined, an auto-repeat counter.
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous active-low reset
//   tick_en        in   one-clock sampling strobe
//   key_n          in   raw asynchronous button, 0 = pressed
//   held           out  debounced level, 1 = pressed (registered)
//   press_pulse    out  one-clock pulse per accepted press (and per repeat)
//   release_pulse  out  one-clock pulse per accepted release
// ---------------------------------------------------------------------------
module key_debounce_channel
  import key_press_pkg::*;
#(
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter int REPEAT_TICKS = DEFAULT_REPEAT_TICKS
) (
  input  logic clock,
  input  logic reset,
  input  logic tick_en,
  input  logic key_n,
  output logic held,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = cnt_width(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic            sync1_r;
  logic            sync2_r;
  logic            sample_s;
  key_state_t      state_r;
  key_state_t      state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_nxt_s;
  logic            press_fsm_s;
  logic            release_nxt_s;
  logic            rep_pulse_s;
  logic            held_r;
  logic            press_r;
  logic            release_r;

  assign sample_s = ~sync2_r;

  // Two-flop synchronizer; resets to the released level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Debounce next-state: a level change is accepted only after
  // STABLE_TICKS consecutive ticks agree; any disagreeing tick restarts it.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    press_fsm_s   = 1'b0;
    release_nxt_s = 1'b0;
    if (tick_en) begin
      case (state_r)
        RELEASED: begin
          if (sample_s) begin
            if (STABLE_TICKS == 1) begin
              state_nxt_s = HELD;
              cnt_nxt_s   = CNT_ZERO;
              press_fsm_s = 1'b1;
            end else begin
              state_nxt_s = PRESSING;
              cnt_nxt_s   = CNT_ONE;
            end
          end else begin
            state_nxt_s = RELEASED;
          end
        end
        PRESSING: begin
          if (!sample_s) begin
            state_nxt_s = RELEASED;
            cnt_nxt_s   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_nxt_s = HELD;
            cnt_nxt_s   = CNT_ZERO;
            press_fsm_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        HELD: begin
          if (!sample_s) begin
            if (STABLE_TICKS == 1) begin
              state_nxt_s   = RELEASED;
              cnt_nxt_s     = CNT_ZERO;
              release_nxt_s = 1'b1;
            end else begin
              state_nxt_s = RELEASING;
              cnt_nxt_s   = CNT_ONE;
            end
          end else begin
            state_nxt_s = HELD;
          end
        end
        RELEASING: begin
          if (sample_s) begin
            state_nxt_s = HELD;
            cnt_nxt_s   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_nxt_s   = RELEASED;
            cnt_nxt_s     = CNT_ZERO;
            release_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s = RELEASED;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
    end
  end

`ifdef KEY_PRESS_CONDITIONER_AUTOREPEAT_EN
  localparam int RW = cnt_width(REPEAT_TICKS);
  localparam logic [RW-1:0] REP_ZERO = {RW{1'b0}};
  localparam logic [RW-1:0] REP_ONE  = RW'(1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

  logic [RW-1:0] rep_r;
  logic [RW-1:0] rep_nxt_s;

  // Repeat counter: runs only on ticks that keep the key in HELD, pauses
  // while RELEASING, and restarts from zero on every (re-)entry to HELD.
  always_comb begin
    rep_nxt_s   = rep_r;
    rep_pulse_s = 1'b0;
    if (tick_en && (state_r == HELD) && (state_nxt_s == HELD)) begin
      if (rep_r == REP_LAST) begin
        rep_nxt_s   = REP_ZERO;
        rep_pulse_s = 1'b1;
      end else begin
        rep_nxt_s = rep_r + REP_ONE;
      end
    end else if ((state_nxt_s == HELD) && (state_r != HELD)) begin
      rep_nxt_s = REP_ZERO;
    end else begin
      rep_nxt_s = rep_r;
    end
  end

  // Repeat counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rep_r <= REP_ZERO;
    end else begin
      rep_r <= rep_nxt_s;
    end
  end
`else
  assign rep_pulse_s = 1'b0;
`endif

  // FSM state and registered outputs; held and pulses move on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= RELEASED;
      cnt_r     <= CNT_ZERO;
      held_r    <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      held_r    <= (state_nxt_s == HELD) || (state_nxt_s == RELEASING);
      press_r   <= press_fsm_s | rep_pulse_s;
      release_r <= release_nxt_s;
    end
  end

  assign held          = held_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;

endmodule

// File: rtl/key_press_conditioner.sv
// ---------------------------------------------------------------------------
// key_press_conditioner
// Converts NUM_KEYS bouncy active-low buttons into debounced levels and
// one-clock press/release pulses, sampled on rising edges of one
// divided-clock bit. Optional auto-repeat: KEY_PRESS_CONDITIONER_AUTOREPEAT_EN.
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous active-low reset
//   tick_src       in   divided-clock bit, already in the clock domain
//   key_n          in   [NUM_KEYS] raw buttons, 0 = pressed
//   held           out  [NUM_KEYS] debounced level, 1 = pressed
//   press_pulse    out  [NUM_KEYS] one-clock pulse per accepted press
//   release_pulse  out  [NUM_KEYS] one-clock pulse per accepted release
// ---------------------------------------------------------------------------
module key_press_conditioner
  import key_press_pkg::*;
#(
  parameter int NUM_KEYS     = 4,
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter int REPEAT_TICKS = DEFAULT_REPEAT_TICKS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick_src,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] held,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);

  logic tick_q_r;
  logic tick_en_s;

  // Previous tick_src value for rising-edge detection; tick_src is already
  // synchronous, so it needs no synchronizer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_q_r <= 1'b0;
    end else begin
      tick_q_r <= tick_src;
    end
  end

  assign tick_en_s = tick_src & ~tick_q_r;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_channel (
      .clock         (clock),
      .reset         (reset),
      .tick_en       (tick_en_s),
      .key_n         (key_n[k]),
      .held          (held[k]),
      .press_pulse   (press_pulse[k]),
      .release_pulse (release_pulse[k])
    );
  end

endmodule

// File: tb/tb_key_press_conditioner.sv
// Bench for key_press_conditioner: directed scenarios followed by randomized
// key/tick activity, each cycle compared against a run-length reference model.
module tb_key_press_conditioner;

  localparam int NK = 4;
  localparam int ST = 3;
  localparam int RT = 8;

  logic          clock    = 1'b0;
  logic          reset    = 1'b1;
  logic          tick_src = 1'b0;
  logic [NK-1:0] key_n    = 4'b1111;
  logic [NK-1:0] held;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;

  int checks   = 0;
  int failures = 0;

  // Reference model: accepted level per key plus the run length of
  // consecutive ticks that disagree with it.
  logic [NK-1:0] m_s1, m_s2;
  logic          m_tq;
  logic [NK-1:0] m_acc;
  int            m_run [NK];
  int            m_rep [NK];
  logic [NK-1:0] e_press, e_rel;

  int ph        = 0;
  int tick_mode = 0;

  always #5 clock = ~clock;

  key_press_conditioner #(
    .NUM_KEYS     (NK),
    .STABLE_TICKS (ST),
    .REPEAT_TICKS (RT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .tick_src      (tick_src),
    .key_n         (key_n),
    .held          (held),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  task automatic check_vec(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1    = 4'b1111;
    m_s2    = 4'b1111;
    m_tq    = 1'b0;
    m_acc   = 4'b0000;
    e_press = 4'b0000;
    e_rel   = 4'b0000;
    for (int k = 0; k < NK; k++) begin
      m_run[k] = 0;
      m_rep[k] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_edge();
    logic tick;
    logic samp;
    if (!reset) begin
      model_reset();
    end else begin
      tick    = tick_src & ~m_tq;
      e_press = 4'b0000;
      e_rel   = 4'b0000;
      if (tick) begin
        for (int k = 0; k < NK; k++) begin
          samp = ~m_s2[k];
          if (samp != m_acc[k]) begin
            m_run[k]++;
            if (m_run[k] >= ST) begin
              m_acc[k] = samp;
              m_run[k] = 0;
              m_rep[k] = 0;
              if (samp) e_press[k] = 1'b1;
              else      e_rel[k]   = 1'b1;
            end
          end else if (m_run[k] > 0) begin
            m_run[k] = 0;
            m_rep[k] = 0;
          end
`ifdef KEY_PRESS_CONDITIONER_AUTOREPEAT_EN
          else if (m_acc[k]) begin
            m_rep[k]++;
            if (m_rep[k] == RT) begin
              e_press[k] = 1'b1;
              m_rep[k]   = 0;
            end
          end
`endif
        end
      end
      m_tq = tick_src;
      m_s2 = m_s1;
      m_s1 = key_n;
    end
  endtask

  // One clock: drive inputs, let the edge happen, compare #1 later.
  task automatic cyc(input logic [NK-1:0] kn);
    case (tick_mode)
      0:       tick_src = ((ph % 4) < 2);
      1:       tick_src = 1'($urandom_range(0, 1));
      2:       tick_src = 1'b1;
      default: tick_src = 1'b0;
    endcase
    ph++;
    key_n = kn;
    @(posedge clock);
    model_edge();
    #1;
    check_vec("held", held, m_acc);
    check_vec("press_pulse", press_pulse, e_press);
    check_vec("release_pulse", release_pulse, e_rel);
  endtask

  // Assert reset between clock edges and check outputs clear immediately.
  task automatic areset();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_vec("async_held", held, 4'b0000);
    check_vec("async_press", press_pulse, 4'b0000);
    check_vec("async_release", release_pulse, 4'b0000);
  endtask

  initial begin
    logic [NK-1:0] kn;
    logic [1:0]    pair;
    int            cnt;
    int            cnt2;

    model_reset();
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(4'b1111);
    reset = 1'b1;

    // Idle: 20 ticks, no activity.
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      cyc(4'b1111);
      cnt += $countones(press_pulse | release_pulse);
    end
    check_int("idle_pulses", cnt, 0);

    // Key 0 pressed and held.
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(4'b1110);
      cnt += int'(press_pulse[0]);
    end
    check_int("key0_press_count", cnt, 1);

    // Key 1 bounces on alternate ticks, then settles pressed.
    cnt = 0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 4; i++) begin
        cyc((b % 2 == 0) ? 4'b1100 : 4'b1110);
        cnt += int'(press_pulse[1]);
      end
    end
    check_int("key1_bounce_pulses", cnt, 0);
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(4'b1100);
      cnt += int'(press_pulse[1]);
    end
    check_int("key1_settled_press", cnt, 1);

    // Release key 0 while key 1 stays held.
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(4'b1101);
      cnt += int'(release_pulse[0]);
    end
    check_int("key0_release_count", cnt, 1);
    check_vec("held_after_release", held, 4'b0010);

    // Keys 2 and 3 pressed on the same clock.
    pair = 2'b00;
    for (int i = 0; i < 24; i++) begin
      cyc(4'b0001);
      if ((press_pulse[2] | press_pulse[3]) && (pair == 2'b00)) pair = press_pulse[3:2];
    end
    check_int("key23_same_cycle", int'(pair), 3);

    // Reset while keys are held, then re-acceptance.
    areset();
    for (int i = 0; i < 3; i++) cyc(4'b0001);
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(4'b0001);
      cnt += int'(press_pulse[2]);
    end
    check_int("key2_reaccept", cnt, 1);

    // Randomized activity with varied tick behaviour and occasional resets.
    kn = 4'b1111;
    for (int i = 0; i < 2400; i++) begin
      if ((i % 120) == 0) tick_mode = (i < 1200) ? 0 : int'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) kn[$urandom_range(0, NK - 1)] ^= 1'b1;
      if ($urandom_range(0, 399) == 0) begin
        areset();
        cyc(kn);
        reset = 1'b1;
      end
      cyc(kn);
    end
    tick_mode = 0;

    // Long hold on key 0 from a clean released state.
    for (int i = 0; i < 40; i++) cyc(4'b1111);
    cnt  = 0;
    cnt2 = 0;
    for (int i = 0; i < 96; i++) begin
      cyc(4'b1110);
      cnt  += int'(press_pulse[0]);
      cnt2 += int'(release_pulse[0]);
    end
`ifdef KEY_PRESS_CONDITIONER_AUTOREPEAT_EN
    check_int("long_hold_press_count", cnt, 3);
`else
    check_int("long_hold_press_count", cnt, 1);
`endif
    check_int("long_hold_release_count", cnt2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_press_conditioner.md
Name: key_press_conditioner

Overview:
- Consumes one tap of the free-running divided-clock bus as its sampling tick.
- Turns NUM_KEYS raw, bouncy, active-low push-button inputs into clean held levels and exactly-one-clock press pulses for the game FSMs.
- Sits between the board KEY pins and the game logic; it is the stage directly downstream of the clock divider.

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- STABLE_TICKS, 3, consecutive equal samples required to accept a level change (>= 1).
- REPEAT_TICKS, 8, ticks between auto-repeat pulses while held (used only with AUTOREPEAT_EN).

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-low reset.
- tick_src  in  1  one divided-clock bit (level signal, same clock domain).
- key_n  in  NUM_KEYS  raw buttons, asynchronous, 0 = pressed.
- held  out  NUM_KEYS  debounced level, 1 = pressed.
- press_pulse  out  NUM_KEYS  one-clock pulse per accepted press.
- release_pulse  out  NUM_KEYS  one-clock pulse per accepted release.

Behaviour:
- Reset (reset low, asynchronous):
  - held, press_pulse and release_pulse all 0.
  - All channels in RELEASED, counters 0.
  - Synchronizer flops set to 1 (released); tick_q set to 0.
- Tick generation:
  - tick_q <= tick_src every clock; tick_en = tick_src & ~tick_q.
  - tick_en is high for exactly one clock per rising edge of tick_src.
  - tick_src is not synchronized, because it is already in the clock domain.
- Input synchronization: key_n passes through 2 flops per bit; sample = ~sync2 (1 = pressed). This gives 2 clocks of synchronizer latency.
- Per-channel FSM (counter cnt, width $clog2(STABLE_TICKS+1)). All transitions are evaluated only when tick_en = 1; otherwise state and cnt hold.
  - RELEASED:
    - sample = 1: cnt <= 1. If STABLE_TICKS == 1, go straight to HELD with a press pulse. Otherwise go to PRESSING.
    - sample = 0: stay.
  - PRESSING:
    - sample = 0: go to RELEASED, cnt <= 0. A bounce restarts the count.
    - sample = 1 and cnt == STABLE_TICKS-1: go to HELD, cnt <= 0, press_pulse = 1 in the next cycle.
    - otherwise: cnt++.
  - HELD: mirror of RELEASED, entering RELEASING on sample = 0.
  - RELEASING: mirror of PRESSING. Return to HELD on sample = 1. Go to RELEASED with release_pulse when STABLE_TICKS samples are reached.
- held = 1 in HELD and RELEASING; it is registered and changes on the same edge as the pulse.
- Pulses:
  - Registered, high for exactly 1 clock, never two consecutive cycles.
  - Press and release pulses of one channel are never high together.
- Latency: press is accepted on the STABLE_TICKS-th consecutive pressed tick; the pulse appears 1 clock after that tick_en cycle.
- Channels are fully independent; simultaneous presses on several keys produce simultaneous pulses.
- Reset mid-press:
  - Channel returns to RELEASED and any pending or partial pulse is dropped.
  - A key still held after reset deasserts is accepted as a new press after STABLE_TICKS ticks.
- tick_src stuck high or low: no tick_en, so all FSMs freeze and outputs keep their values; pulses still last only one clock.

Optional Feature:
- Macro: KEY_PRESS_CONDITIONER_AUTOREPEAT_EN.
- Defined:
  - Each channel has a repeat counter, cleared on entry to HELD.
  - While in HELD, it increments on tick_en. When it reaches REPEAT_TICKS-1 it emits a press_pulse and wraps to 0.
  - The counter pauses in RELEASING and is cleared on return to HELD.
- Undefined: no repeat logic is instantiated; exactly one press_pulse per accepted press.

Decomposition:
- Package key_press_pkg:
  - typedef enum logic [1:0] {RELEASED, PRESSING, HELD, RELEASING} key_state_t.
  - Default constants for STABLE_TICKS and REPEAT_TICKS.
- Sub-module key_debounce_channel:
  - Single-bit synchronizer, FSM, counter and optional repeat logic.
  - Instantiated NUM_KEYS times via generate.
- Top level holds the tick edge detector and the per-key generate loop.

Test Plan (STABLE_TICKS = 3; tick_src driven by the bench, high 2 clocks, low 2 clocks):
- Reset low 3 clocks with key_n = 4'b1111, then release: held = 0, both pulse vectors 0, and no pulse for 20 ticks.
- key_n[0] = 0 held: press_pulse[0] high exactly 1 clock, one clock after the 3rd tick_en following sync; held[0] = 1 from the same edge.
- key_n[1] bounces 0,1,0,1 on alternate ticks, then steady 0: no pulse during the bounce; one pulse after 3 steady ticks.
- Release key 0 after it is held: release_pulse[0] high 1 clock after 3 released ticks; held[0] falls on the same edge.
- Keys 2 and 3 pressed on the same clock: press_pulse[3:2] = 2'b11 on the same cycle.
- Key held, reset pulsed low mid-HELD: outputs clear asynchronously; after reset release the key is re-accepted with one press_pulse after 3 ticks.
- With AUTOREPEAT_EN and REPEAT_TICKS = 8, key held for 20 ticks after acceptance: 1 initial pulse plus 2 repeat pulses (at 8 and 16 ticks after entering HELD).
